// File: rtl/eth_tx_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_rr_arbiter
// Description : Packet-level round-robin arbiter sharing the 100G MAC TX
//               AXI-Stream port among P_CHANNEL_NUM channels.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_rr_arbiter #(
    parameter int P_CHANNEL_NUM = 2,
    parameter int P_DATA_WIDTH  = 512,
    parameter int P_KEEP_WIDTH  = 64,
    parameter int P_ID_WIDTH    = 1
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_link_up,
    input  logic [P_CHANNEL_NUM*P_DATA_WIDTH-1:0] i_s_axis_tdata,
    input  logic [P_CHANNEL_NUM*P_KEEP_WIDTH-1:0] i_s_axis_tkeep,
    input  logic [P_CHANNEL_NUM-1:0]              i_s_axis_tlast,
    input  logic [P_CHANNEL_NUM-1:0]              i_s_axis_tvalid,
    output logic [P_CHANNEL_NUM-1:0]              o_s_axis_tready,
    output logic [P_DATA_WIDTH-1:0]               o_m_axis_tdata,
    output logic [P_KEEP_WIDTH-1:0]               o_m_axis_tkeep,
    output logic                                  o_m_axis_tlast,
    output logic                                  o_m_axis_tvalid,
    input  logic                                  i_m_axis_tready,
    output logic [P_ID_WIDTH-1:0]                 o_grant_id,
    output logic                                  o_busy,
    output logic [31:0]                           o_pkt_cnt
);

    localparam logic [0:0]            c_IDLE      = 1'b0;
    localparam logic [0:0]            c_XFER      = 1'b1;
    // Pointer starts on the highest channel so channel 0 wins first after reset.
    localparam logic [P_ID_WIDTH-1:0] c_LAST_INIT = P_ID_WIDTH'(P_CHANNEL_NUM - 1);

    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;
    logic [P_ID_WIDTH-1:0]   r_grant_id;
    logic [P_ID_WIDTH-1:0]   r_last_grant;
    logic [31:0]             r_pkt_cnt;

    logic                    w_arb_found;
    logic [P_ID_WIDTH-1:0]   w_arb_pick;
    logic                    w_grant_load;
    logic                    w_pkt_done;

    logic [P_DATA_WIDTH-1:0] w_sel_data;
    logic [P_KEEP_WIDTH-1:0] w_sel_keep;
    logic                    w_sel_last;
    logic                    w_sel_valid;

    // First requester found scanning upward from last_grant+1, modulo channel count.
    always_comb begin : arb_search
        w_arb_found = 1'b0;
        w_arb_pick  = '0;
        for (int i = 1; i <= P_CHANNEL_NUM; i++) begin
            for (int j = 0; j < P_CHANNEL_NUM; j++) begin
                if (!w_arb_found && i_s_axis_tvalid[j] &&
                    (j == ((int'(r_last_grant) + i) % P_CHANNEL_NUM))) begin
                    w_arb_found = 1'b1;
                    w_arb_pick  = P_ID_WIDTH'(j);
                end
            end
        end
    end

    always_comb begin : sel_mux
        w_sel_data  = '0;
        w_sel_keep  = '0;
        w_sel_last  = 1'b0;
        w_sel_valid = 1'b0;
        for (int j = 0; j < P_CHANNEL_NUM; j++) begin
            if (r_grant_id == P_ID_WIDTH'(j)) begin
                w_sel_data  = i_s_axis_tdata[j*P_DATA_WIDTH +: P_DATA_WIDTH];
                w_sel_keep  = i_s_axis_tkeep[j*P_KEEP_WIDTH +: P_KEEP_WIDTH];
                w_sel_last  = i_s_axis_tlast[j];
                w_sel_valid = i_s_axis_tvalid[j];
            end
        end
    end

    always_comb begin : fsm_comb
        w_state_nxt     = r_state;
        w_grant_load    = 1'b0;
        w_pkt_done      = 1'b0;
        o_m_axis_tdata  = '0;
        o_m_axis_tkeep  = '0;
        o_m_axis_tlast  = 1'b0;
        o_m_axis_tvalid = 1'b0;
        o_s_axis_tready = '0;
        case (r_state)
            c_IDLE: begin
                if (i_link_up && w_arb_found) begin
                    w_grant_load = 1'b1;
                    w_state_nxt  = c_XFER;
                end
            end
            c_XFER: begin
                o_m_axis_tdata  = w_sel_data;
                o_m_axis_tkeep  = w_sel_keep;
                o_m_axis_tlast  = w_sel_last;
                o_m_axis_tvalid = w_sel_valid;
                for (int j = 0; j < P_CHANNEL_NUM; j++) begin
                    if (r_grant_id == P_ID_WIDTH'(j)) begin
                        o_s_axis_tready[j] = i_m_axis_tready;
                    end
                end
                // Link status is ignored here: an in-flight packet always completes.
                w_pkt_done = w_sel_valid && i_m_axis_tready && w_sel_last;
                if (w_pkt_done) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin : fsm_reg
        if (!i_rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin : grant_reg
        if (!i_rst_n) begin
            r_grant_id   <= '0;
            r_last_grant <= c_LAST_INIT;
            r_pkt_cnt    <= '0;
        end else begin
            if (w_grant_load) begin
                r_grant_id   <= w_arb_pick;
                r_last_grant <= w_arb_pick;
            end
            if (w_pkt_done) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
        end
    end

    assign o_grant_id = r_grant_id;
    assign o_busy     = (r_state == c_XFER);
    assign o_pkt_cnt  = r_pkt_cnt;

endmodule
`default_nettype wire

// File: doc/eth_tx_rr_arbiter.md
Name: eth_tx_rr_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single 100G MAC TX AXI-Stream port among P_CHANNEL_NUM user channels.
- Sits between the per-channel TX packet sources and the 512-bit MAC TX interface in the 100G Ethernet top.
- Grants whole packets only: no interleaving inside a frame.
- Gates new grants on link status.

Parameters:
- P_CHANNEL_NUM, 2, number of requesting channels (1..8)
- P_DATA_WIDTH, 512, AXIS data width per channel
- P_KEEP_WIDTH, 64, AXIS keep width (P_DATA_WIDTH/8)
- P_ID_WIDTH, 1, grant id width; must satisfy 2**P_ID_WIDTH >= P_CHANNEL_NUM; minimum 1

Ports:
- i_clk  in  1  datapath clock, MAC TX user clock
- i_rst_n  in  1  synchronous, active-low reset
- i_link_up  in  1  MAC/GT link status; 1 = link usable
- i_s_axis_tdata  in  P_CHANNEL_NUM*P_DATA_WIDTH  channel data; channel k occupies slice k
- i_s_axis_tkeep  in  P_CHANNEL_NUM*P_KEEP_WIDTH  channel byte enables
- i_s_axis_tlast  in  P_CHANNEL_NUM  end-of-packet per channel
- i_s_axis_tvalid  in  P_CHANNEL_NUM  valid per channel
- o_s_axis_tready  out  P_CHANNEL_NUM  ready per channel
- o_m_axis_tdata  out  P_DATA_WIDTH  to MAC TX
- o_m_axis_tkeep  out  P_KEEP_WIDTH  to MAC TX
- o_m_axis_tlast  out  1  to MAC TX
- o_m_axis_tvalid  out  1  to MAC TX
- i_m_axis_tready  in  1  from MAC TX
- o_grant_id  out  P_ID_WIDTH  channel currently or last granted
- o_busy  out  1  1 while a packet is in flight (XFER state)
- o_pkt_cnt  out  32  total packets forwarded; wraps at 2^32

Behaviour:
- FSM has two states, IDLE and XFER. Reset state is IDLE.
- Reset values:
  - o_grant_id=0, o_busy=0, o_pkt_cnt=0.
  - o_m_axis_tvalid=0, o_s_axis_tready=0.
  - Internal last-grant pointer = P_CHANNEL_NUM-1, so channel 0 has first priority after reset.
- IDLE:
  - o_m_axis_tvalid=0; all o_s_axis_tready=0.
  - If i_link_up=1 and any i_s_axis_tvalid=1: select the first valid channel searching upward from last_grant+1, wrapping modulo P_CHANNEL_NUM.
  - On selection: register o_grant_id, update last_grant, go to XFER.
  - If i_link_up=0: stay in IDLE regardless of requests.
- XFER, with g = o_grant_id:
  - Combinational pass-through: o_m_axis_tdata/tkeep/tlast/tvalid = slice g of the inputs; o_s_axis_tready[g] = i_m_axis_tready. All other readies = 0.
  - A beat transfers when tvalid[g] & i_m_axis_tready.
  - When a transferring beat has tlast=1: increment o_pkt_cnt, go to IDLE.
  - o_busy=1 throughout XFER.
- Latency:
  - Request seen in IDLE in cycle N → first beat can be presented in cycle N+1.
  - One idle bubble cycle between consecutive packets (IDLE re-arbitration cycle).
- i_link_up falling during XFER: the current packet completes normally; no truncation. The block then stays in IDLE until link_up=1.
- Source deasserting tvalid mid-packet: the grant is held, output tvalid=0, no re-arbitration until tlast.
- Single requester: it is re-granted every packet, with one bubble between packets.
- P_CHANNEL_NUM=1: the pointer is always 0 and the search is trivial.
- Reset asserted mid-packet: return to IDLE next cycle with all reset values; the partial packet is abandoned (MAC sees tvalid drop without tlast; accepted by design).
- The block does no buffering and has no internal data registers. tdata/tkeep of non-granted channels are ignored.

Test Plan:
- Reset, link_up=1, channel 0 sends a 3-beat packet with tready=1 → grant_id=0; output beats appear cycles 1..3 after the request; pkt_cnt=1; o_busy falls after the tlast beat.
- Both channels continuously valid, 2-beat packets, tready=1 → grant order 0,1,0,1; one bubble between packets; pkt_cnt=4 after 4 packets; channel 1 tready=0 while channel 0 is granted.
- Channel 1 mid-packet with MAC tready toggling 1,0,1,0 → o_s_axis_tready[1] mirrors it; no beat lost or duplicated; tdata matches the source beat-for-beat.
- link_up=0 with channel 0 valid → no grant, o_m_axis_tvalid=0 indefinitely. Raise link_up → grant on the next cycle. Drop link_up during beat 2 of 4 → all 4 beats delivered, then no new grant.
- Reset asserted at beat 2 of a 5-beat packet → next cycle: o_busy=0, tvalid=0, pkt_cnt=0, grant_id=0. The next grant goes to channel 0 when both channels request.
- Preload o_pkt_cnt to 0xFFFF_FFFF by force, send one packet → o_pkt_cnt wraps to 0.
